// File: rtl/carrier_phase_scheduler.sv
// rtl/carrier_phase_scheduler.sv - BPSK carrier phase sequencer with symbol fetch
//
// Purpose:
//   Advances a fixed-point carrier phase once per processed sample tick. One
//   symbol bit is fetched every SAMPLES_PER_SYMBOL samples over a valid/ready
//   handshake. A '1' bit adds a pi offset. The LUT step index is tracked with a
//   counter, so no per-sample divide is needed. The accumulator is forced to
//   zero on every carrier-period wrap, which removes truncation drift.
//
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   enable         run request; low returns to IDLE and clears all state
//   sample_tick    one-cycle strobe per DAC sample
//   sym_valid      symbol source has a bit
//   sym_bit        symbol bit (1 = pi offset)
//   sym_ready      combinational; symbol accepted when sym_valid is also high
//   phase_out      wrapped phase in [0, M_2_PI), registered
//   phase_in_step  LUT index in [0, SAMPLES-1], registered
//   step_valid     one-cycle pulse; phase_out/phase_in_step updated
//   symbol_start   pulses with step_valid on the first sample of a symbol
//   sym_underrun   sticky; set when a boundary finds no symbol
module carrier_phase_scheduler #(
  parameter int                     INPUT_WIDTH        = 64,
  parameter logic [INPUT_WIDTH-1:0] M_2_PI             = 64'h00003243f6a8885a,
  parameter int                     SAMPLES            = 8,
  parameter int                     SAMPLES_PER_SYMBOL = 16,
  parameter logic [INPUT_WIDTH-1:0] PHASE_STEP         = M_2_PI / INPUT_WIDTH'(SAMPLES)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          enable,
  input  logic                          sample_tick,
  input  logic                          sym_valid,
  input  logic                          sym_bit,
  output logic                          sym_ready,
  output logic signed [INPUT_WIDTH-1:0] phase_out,
  output logic [$clog2(SAMPLES)-1:0]    phase_in_step,
  output logic                          step_valid,
  output logic                          symbol_start,
  output logic                          sym_underrun
);

  localparam int IDX_W = $clog2(SAMPLES);
  localparam int CNT_W = (SAMPLES_PER_SYMBOL > 1) ? $clog2(SAMPLES_PER_SYMBOL) : 1;
  localparam logic [INPUT_WIDTH-1:0] M_PI = M_2_PI >> 1;

  typedef enum logic [1:0] {IDLE, LOAD, RUN, UNDERRUN} state_t;

  state_t                 state_q, state_d;
  logic [INPUT_WIDTH-1:0] acc_q, acc_d;
  logic [IDX_W-1:0]       car_idx_q, car_idx_d;
  logic [CNT_W-1:0]       sym_cnt_q, sym_cnt_d;
  logic                   cur_bit_q, cur_bit_d;
  logic                   underrun_q, underrun_d;
  logic [INPUT_WIDTH-1:0] phase_q, phase_d;
  logic [IDX_W-1:0]       step_q, step_d;
  logic                   step_valid_q, step_valid_d;
  logic                   symbol_start_q, symbol_start_d;

  logic                   active;
  logic                   boundary;
  logic [IDX_W-1:0]       car_next;
  logic [INPUT_WIDTH-1:0] acc_next;
  logic [CNT_W-1:0]       sym_next;
  logic                   bit_v;
  logic [IDX_W:0]         step_sum;
  logic [INPUT_WIDTH:0]   phase_sum;

  assign active   = (state_q == RUN) || (state_q == UNDERRUN);
  assign boundary = (sym_cnt_q == CNT_W'(SAMPLES_PER_SYMBOL - 1));
  assign car_next = (car_idx_q == IDX_W'(SAMPLES - 1)) ? '0 : car_idx_q + 1'b1;
  // Period wrap lands exactly on zero instead of accumulating the truncated step.
  assign acc_next = (car_next == '0) ? '0 : acc_q + PHASE_STEP;
  assign sym_next = boundary ? '0 : sym_cnt_q + 1'b1;

  assign sym_ready = enable && ((state_q == LOAD) || (active && boundary && sample_tick));

  always_comb begin
    state_d        = state_q;
    acc_d          = acc_q;
    car_idx_d      = car_idx_q;
    sym_cnt_d      = sym_cnt_q;
    cur_bit_d      = cur_bit_q;
    underrun_d     = underrun_q;
    phase_d        = phase_q;
    step_d         = step_q;
    step_valid_d   = 1'b0;
    symbol_start_d = 1'b0;
    bit_v          = cur_bit_q;
    step_sum       = '0;
    phase_sum      = '0;

    if (!enable) begin
      state_d    = IDLE;
      acc_d      = '0;
      car_idx_d  = '0;
      sym_cnt_d  = '0;
      cur_bit_d  = 1'b0;
      underrun_d = 1'b0;
      phase_d    = '0;
      step_d     = '0;
    end else begin
      case (state_q)
        IDLE: state_d = LOAD;
        LOAD: begin
          if (sym_valid) begin
            cur_bit_d = sym_bit;
            sym_cnt_d = '0;
            state_d   = RUN;
          end
        end
        RUN, UNDERRUN: begin
          if (sample_tick) begin
            if (boundary) begin
              if (sym_valid) begin
                bit_v   = sym_bit;
                state_d = RUN;
              end else begin
                // Starved source: fall back to the unmodulated carrier.
                bit_v      = 1'b0;
                state_d    = UNDERRUN;
                underrun_d = 1'b1;
              end
            end
            cur_bit_d      = bit_v;
            car_idx_d      = car_next;
            acc_d          = acc_next;
            sym_cnt_d      = sym_next;
            step_valid_d   = 1'b1;
            symbol_start_d = (sym_next == '0);

            step_sum = {1'b0, car_next} + (bit_v ? (IDX_W+1)'(SAMPLES / 2) : '0);
            if (step_sum >= (IDX_W+1)'(SAMPLES)) step_sum = step_sum - (IDX_W+1)'(SAMPLES);
            step_d = step_sum[IDX_W-1:0];

            // Extra bit holds acc + pi before the single conditional wrap.
            phase_sum = {1'b0, acc_next} + (bit_v ? {1'b0, M_PI} : '0);
            if (phase_sum >= {1'b0, M_2_PI}) phase_sum = phase_sum - {1'b0, M_2_PI};
            phase_d = phase_sum[INPUT_WIDTH-1:0];
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      acc_q          <= '0;
      car_idx_q      <= '0;
      sym_cnt_q      <= '0;
      cur_bit_q      <= 1'b0;
      underrun_q     <= 1'b0;
      phase_q        <= '0;
      step_q         <= '0;
      step_valid_q   <= 1'b0;
      symbol_start_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      acc_q          <= acc_d;
      car_idx_q      <= car_idx_d;
      sym_cnt_q      <= sym_cnt_d;
      cur_bit_q      <= cur_bit_d;
      underrun_q     <= underrun_d;
      phase_q        <= phase_d;
      step_q         <= step_d;
      step_valid_q   <= step_valid_d;
      symbol_start_q <= symbol_start_d;
    end
  end

  assign phase_out     = phase_q;
  assign phase_in_step = step_q;
  assign step_valid    = step_valid_q;
  assign symbol_start  = symbol_start_q;
  assign sym_underrun  = underrun_q;

endmodule

// File: tb/tb_carrier_phase_scheduler.sv
// tb/tb_carrier_phase_scheduler.sv - bench for carrier_phase_scheduler
module tb_carrier_phase_scheduler;

  localparam int          S    = 8;
  localparam int          SPS  = 4;
  localparam logic [63:0] M2PI = 64'h00003243f6a8885a;
  localparam logic [63:0] STEP = 64'h000006487ed5110b;
  localparam logic [63:0] MPI  = 64'h00001921fb54442d;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               enable = 1'b0;
  logic               sample_tick = 1'b0;
  logic               sym_valid = 1'b0;
  logic               sym_bit = 1'b0;
  logic               sym_ready;
  logic signed [63:0] phase_out;
  logic [2:0]         phase_in_step;
  logic               step_valid;
  logic               symbol_start;
  logic               sym_underrun;

  int total_cnt = 0;
  int pass_cnt  = 0;

  // Reference: 0 = idle, 1 = waiting for first symbol, 2 = running.
  int          m_state = 0;
  int          m_n     = 0;
  bit          m_bit   = 0;
  bit          m_under = 0;
  logic [63:0] e_phase = '0;
  logic [63:0] e_step  = '0;
  bit          e_sv    = 0;
  bit          e_ss    = 0;

  carrier_phase_scheduler #(
    .INPUT_WIDTH(64), .M_2_PI(M2PI), .SAMPLES(S), .SAMPLES_PER_SYMBOL(SPS)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .sample_tick(sample_tick),
    .sym_valid(sym_valid), .sym_bit(sym_bit), .sym_ready(sym_ready),
    .phase_out(phase_out), .phase_in_step(phase_in_step), .step_valid(step_valid),
    .symbol_start(symbol_start), .sym_underrun(sym_underrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic check_outputs();
    check("step_valid",    64'(step_valid),    64'(e_sv));
    check("phase_out",     phase_out,          e_phase);
    check("phase_in_step", 64'(phase_in_step), e_step);
    check("symbol_start",  64'(symbol_start),  64'(e_ss));
    check("sym_underrun",  64'(sym_underrun),  64'(m_under));
  endtask

  task automatic model_clear();
    m_state = 0; m_n = 0; m_bit = 0; m_under = 0;
    e_phase = '0; e_step = '0; e_sv = 0; e_ss = 0;
  endtask

  // Called just after a rising edge; drives one cycle and checks both sides.
  task automatic cycle(input bit en, input bit tk, input bit sv, input bit sb);
    bit e_ready;
    int idx;
    enable = en; sample_tick = tk; sym_valid = sv; sym_bit = sb;
    e_ready = en && (m_state == 1 || (m_state == 2 && tk && ((m_n + 1) % SPS == 0)));
    #1;
    check("sym_ready", 64'(sym_ready), 64'(e_ready));
    e_sv = 0; e_ss = 0;
    if (!en) begin
      model_clear();
    end else if (m_state == 0) begin
      m_state = 1;
    end else if (m_state == 1) begin
      if (sv) begin m_bit = sb; m_n = 0; m_state = 2; end
    end else if (tk) begin
      m_n++;
      if (m_n % SPS == 0) begin
        if (sv) m_bit = sb;
        else begin m_bit = 0; m_under = 1; end
      end
      idx     = m_n % S;
      e_step  = 64'((idx + (m_bit ? S / 2 : 0)) % S);
      e_phase = (64'(idx) * STEP + (m_bit ? MPI : 64'd0)) % M2PI;
      e_sv    = 1;
      e_ss    = (m_n % SPS == 0);
    end
    @(posedge clk); #1;
    check_outputs();
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_sym_ready", 64'(sym_ready), 64'd0);
    check_outputs();
    rst_n = 1'b1;

    // IDLE -> LOAD; ticks ignored while waiting for the first symbol
    cycle(1, 0, 0, 0);
    cycle(1, 1, 0, 0);
    cycle(1, 1, 0, 1);
    cycle(1, 1, 1, 0);

    // Bit 0 carrier on consecutive ticks, through one period wrap
    repeat (8) cycle(1, 1, 1, 0);
    check("wrap_phase_zero", phase_out, 64'd0);
    check("wrap_step_zero", 64'(phase_in_step), 64'd0);
    cycle(1, 1, 1, 0);

    // Bit 1 from the next boundary: LUT index offset by half a period
    repeat (8) cycle(1, 1, 1, 1);

    // Symbol cadence with idle gaps, bits 0,1,0
    for (int i = 0; i < 12; i++) begin
      cycle(1, 1, 1, (i / 4) == 1);
      cycle(1, 0, 1, 0);
    end

    // Underrun at one boundary, recovery at the next
    for (int i = 0; i < 8; i++) cycle(1, 1, i >= 4, 1);
    repeat (4) cycle(1, 1, 1, 0);

    // Enable low mid-symbol, then restart
    cycle(1, 1, 1, 1);
    cycle(0, 1, 1, 1);
    cycle(1, 0, 0, 0);
    cycle(1, 0, 1, 1);
    repeat (6) cycle(1, 1, 1, 1);

    // Randomized stream
    for (int i = 0; i < 600; i++)
      cycle(($urandom_range(0, 39) != 0), $urandom_range(0, 1) == 1,
            $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1);

    // Asynchronous reset mid-symbol
    #2; rst_n = 1'b0; #1;
    model_clear();
    check("async_sym_ready", 64'(sym_ready), 64'd0);
    check_outputs();
    @(posedge clk); #1;
    rst_n = 1'b1;
    cycle(1, 0, 0, 0);
    cycle(1, 0, 1, 0);
    repeat (5) cycle(1, 1, 1, 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
